// File: rtl/dm_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: access sizes, FSM states, byte-enable patterns.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dm_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundles the two requester ports, their response ports and the memory-array port.
// Latency: n/a (wires only).
// Backpressure: reqN_ready is the only backpressure; responses and memory accesses cannot be stalled.
// Modports: slave = arbiter side, master = requester/memory side.
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [1:0]        req0_size;
  logic              req0_sext;
  logic [31:0]       req0_addr;
  logic [31:0]       req0_wdata;
  logic [31:0]       req0_pc;
  logic              rsp0_valid;
  logic [31:0]       rsp0_rdata;
  logic              rsp0_err;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [1:0]        req1_size;
  logic              req1_sext;
  logic [31:0]       req1_addr;
  logic [31:0]       req1_wdata;
  logic [31:0]       req1_pc;
  logic              rsp1_valid;
  logic [31:0]       rsp1_rdata;
  logic              rsp1_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_size, req0_sext, req0_addr, req0_wdata, req0_pc,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_valid, req1_we, req1_size, req1_sext, req1_addr, req1_wdata, req1_pc,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_size, req0_sext, req0_addr, req0_wdata, req0_pc,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_valid, req1_we, req1_size, req1_sext, req1_addr, req1_wdata, req1_pc,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dm_lane_align.sv
// Byte-lane steering for sub-word accesses: byte enables, replicated store data, extended load data.
// Latency: purely combinational.
// Backpressure: none.
// Ports: size/addr_lo/sext/wdata/rword in; be, lane_wdata, rdata, misaligned out.
module dm_lane_align
  import dm_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be         = '0;
    lane_wdata = wdata;
    rdata      = '0;
    misaligned = 1'b0;

    case (addr_lo)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        rdata      = {{24{sext & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        lane_wdata = {2{wdata[15:0]}};
        rdata      = {{16{sext & rhalf[15]}}, rhalf};
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        be         = BE_WORD;
        rdata      = rword;
        misaligned = (addr_lo != 2'b00);
      end
      default: ;  // illegal size is flagged by the caller
    endcase
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU (port 0) and debug/loader (port 1).
// Latency from acceptance: load rsp at +3, store rsp at +2, error rsp at +1; one transaction in flight.
// Backpressure: reqN_ready only in IDLE and only for the winner; requests held by a requester simply wait.
// Ports: clk, reset (async, active-high), bus (dm_port_arbiter_if.slave: req0/1, rsp0/1, mem_*).
// Optional macro DM_ARB_TRACE_EN: prints a store trace line on each store ISSUE cycle.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  dm_port_arbiter_if.slave      bus
);

  state_t            state, state_nxt;
  logic              last_grant;

  logic              any_vld;
  logic              win;
  logic              in_we;
  logic [1:0]        in_size;
  logic              in_sext;
  logic [31:0]       in_addr;
  logic [31:0]       in_wdata;
  logic              in_err;

  logic              lat_port;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_sext;
  logic [ADDR_W+1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [1:0]        al_size;
  logic [1:0]        al_addr_lo;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;
  logic              al_misaligned;

  // On a tie the port that did not win last time gets the grant.
  assign any_vld = bus.req0_valid | bus.req1_valid;
  assign win     = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;

  assign in_we    = win ? bus.req1_we    : bus.req0_we;
  assign in_size  = win ? bus.req1_size  : bus.req0_size;
  assign in_sext  = win ? bus.req1_sext  : bus.req0_sext;
  assign in_addr  = win ? bus.req1_addr  : bus.req0_addr;
  assign in_wdata = win ? bus.req1_wdata : bus.req0_wdata;

  // One aligner serves both phases: in IDLE it judges the incoming request's alignment,
  // afterwards it steers the latched request onto the memory lanes.
  assign al_size    = (state == IDLE) ? in_size      : lat_size;
  assign al_addr_lo = (state == IDLE) ? in_addr[1:0] : lat_addr[1:0];

  dm_lane_align u_align (
    .size       (al_size),
    .addr_lo    (al_addr_lo),
    .sext       (lat_sext),
    .wdata      (lat_wdata),
    .rword      (bus.mem_rdata),
    .be         (al_be),
    .lane_wdata (al_wdata),
    .rdata      (al_rdata),
    .misaligned (al_misaligned)
  );

  assign in_err = (in_size == 2'b11) | al_misaligned | (|(in_addr >> (ADDR_W + 2)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp0_rdata = '0;
    bus.rsp0_err   = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp1_rdata = '0;
    bus.rsp1_err   = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_be     = '0;
    bus.mem_wdata  = '0;

    case (state)
      IDLE: begin
        // Gated by reset so nothing is granted while reset is held.
        bus.req0_ready = any_vld & ~win & ~reset;
        bus.req1_ready = any_vld &  win & ~reset;
        if (any_vld) state_nxt = in_err ? RESP : ISSUE;
      end
      ISSUE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = lat_we;
        bus.mem_addr  = lat_addr[ADDR_W+1:2];
        bus.mem_be    = al_be;
        bus.mem_wdata = al_wdata;
        state_nxt     = lat_we ? RESP : WAIT;
      end
      WAIT: state_nxt = RESP;
      RESP: begin
        bus.rsp0_valid = ~lat_port;
        bus.rsp0_rdata = lat_port ? '0 : rsp_rdata_q;
        bus.rsp0_err   = ~lat_port & rsp_err_q;
        bus.rsp1_valid = lat_port;
        bus.rsp1_rdata = lat_port ? rsp_rdata_q : '0;
        bus.rsp1_err   = lat_port & rsp_err_q;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant  <= 1'b1;
      lat_port    <= 1'b0;
      lat_we      <= 1'b0;
      lat_size    <= '0;
      lat_sext    <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (state == IDLE && any_vld) begin
        last_grant  <= win;
        lat_port    <= win;
        lat_we      <= in_we;
        lat_size    <= in_size;
        lat_sext    <= in_sext;
        lat_addr    <= in_addr[ADDR_W+1:0];
        lat_wdata   <= in_wdata;
        rsp_rdata_q <= '0;
        rsp_err_q   <= in_err;
      end
      if (state == WAIT) rsp_rdata_q <= al_rdata;
    end
  end

`ifdef DM_ARB_TRACE_EN
  logic [31:0] lat_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         lat_pc <= '0;
    else if (state == IDLE && any_vld) lat_pc <= win ? bus.req1_pc : bus.req0_pc;
  end

  always_ff @(posedge clk) begin
    if (!reset && state == ISSUE && lat_we)
      $display("@%h: *%h <= %h", lat_pc, {{(30 - ADDR_W){1'b0}}, lat_addr},
               bus.mem_wdata & {{8{al_be[3]}}, {8{al_be[2]}}, {8{al_be[1]}}, {8{al_be[0]}}});
  end
`else
  // The PC inputs only feed the trace; fold them into a sink so they read as intentionally unused.
  logic unused_pc;
  assign unused_pc = ^{bus.req0_pc, bus.req1_pc};
`endif

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU load/store unit, port 1 is the debug/loader port.
- Round-robin arbitration, one transaction in flight, valid/ready request handshake, one-cycle rvalid response pulse.
- Generates per-byte write enables, lane-replicated write data and sign/zero-extended read data for byte, half and word accesses.
- Sits between the requesters and the memory array; the array has synchronous write and 1-cycle registered read.

Parameters:
- ADDR_W, 12, word-index width; memory holds 2^ADDR_W words.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- reqN_valid  in  1  request valid (N = 0, 1; every reqN_/rspN_ port exists once per requester)
- reqN_ready  out  1  request accepted this cycle
- reqN_we  in  1  1 = store, 0 = load
- reqN_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
- reqN_sext  in  1  sign-extend load result (0 = zero-extend)
- reqN_addr  in  32  byte address
- reqN_wdata  in  32  store data, right-aligned
- reqN_pc  in  32  originating PC; used only for trace
- rspN_valid  out  1  one-cycle response pulse
- rspN_rdata  out  32  load result; 0 for stores and errors
- rspN_err  out  1  misaligned, illegal size or out-of-range access
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  word index, taken from addr[ADDR_W+1:2]
- mem_be  out  4  byte enables; bit i covers bits 8i+7..8i
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset is asynchronous:
  - state returns to IDLE; last_grant is set to 1, so port 0 wins the first tie.
  - All outputs go to 0 and any in-flight transaction is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational and is raised only for the winner; the loser sees 0.
  - Winner: if exactly one port is valid, that port wins. If both are valid, the port not equal to last_grant wins.
  - On acceptance, the request is latched and last_grant is updated to the winner.
  - If the request is erroneous, go to RESP with err=1. Otherwise go to ISSUE.
- Error conditions, all of which cause no memory access:
  - size=11.
  - half access with addr[0]=1.
  - word access with addr[1:0]!=0.
  - addr[31:ADDR_W+2]!=0.
- ISSUE:
  - mem_en=1, mem_we=latched we, mem_addr, mem_be and mem_wdata driven.
  - Store goes to RESP; load goes to WAIT.
- WAIT:
  - mem_rdata is extracted and extended, then registered into the response.
  - Go to RESP.
- RESP:
  - rspN_valid=1 for the latched port only, together with rdata and err.
  - Go to IDLE. ready stays 0 during this cycle.
- Latency, with acceptance at cycle T:
  - load: rsp at T+3
  - store: rsp at T+2
  - error: rsp at T+1
- Maximum throughput is one transaction every 3 (store) or 4 (load) cycles.
- ready is 0 in every non-IDLE state. A requester holds valid and all its fields stable until ready.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Read extraction:
  - byte: lane addr[1:0]
  - half: lane addr[1]
  - word: the full word
  - Byte and half results are extended per sext.
- mem_* outputs are 0 in every state except ISSUE.
- rsp outputs are 0 outside RESP.
- Requests arriving during a busy period are not dropped. They wait, and the round-robin order then applies.

Optional Feature:
- Macro: DM_ARB_TRACE_EN.
- Defined: on each ISSUE cycle with a store, $display("@%h: *%h <= %h", pc, byte_addr, mem_wdata masked by mem_be, other lanes 0).
- Undefined: no display statements; reqN_pc is ignored and synthesis-clean.

Decomposition:
- Package dm_arb_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - BE_WORD/BE_HALF_LO/BE_HALF_HI constants
- Sub-module dm_lane_align, purely combinational:
  - inputs size, addr[1:0], sext, wdata, rword
  - outputs be, lane wdata, extended rdata, misaligned flag
- The FSM and arbiter stay in the top module.

Test Plan:
- Port 0 stores a word 0x12345678 at 0x10, then loads it back → store rsp at T+2 with mem_be=1111 and mem_addr=4; load rsp at T+3 with rdata=0x12345678.
- Store byte 0x80 at 0x13, then load byte at 0x13 with sext=1, then with sext=0 → mem_be=1000 and mem_wdata=0x80808080; results 0xFFFFFF80, then 0x00000080.
- Store half 0xBEEF at 0x22, then load half at 0x22 with sext=1 → mem_be=1100; rdata=0xFFFFBEEF.
- Both ports valid continuously in every IDLE cycle → grants alternate 0,1,0,1; no response lost; each response appears only on its owner's rsp port.
- Word at 0x2, half at 0x1, size=11, and addr 0x4000 (ADDR_W=12) → mem_en never asserted; each gets rsp at T+1 with err=1 and rdata=0.
- Assert reset during WAIT of a load → all outputs 0 immediately; no rsp; the next request after reset is granted to port 0 on a tie.
